psum_collector: RTL and testbench

Receive-side drain for the core's result bus. Captures each full row of `col` partial sums plus the accompanying `sum_out` word into a small FIFO on a capture strobe. Serialises each captured row onto a narrow valid/ready stream, one word per beat, toward the host or test interface. Sits directly downstream of the fullchip `out`/`sum_out` ports.

---
 rtl/psum_collector_if.sv | 28 ++
 rtl/psum_collector.sv | 111 +++++++++++
 tb/tb_psum_collector.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_collector_if.sv
// Capture-side and stream-side signals of the psum collector.
// "master" drives captures and consumes the stream; "slave" is the collector.
interface psum_collector_if #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int depth   = 4
);
  logic                         cap_valid;
  logic [bw_psum*col-1:0]       out_in;
  logic [bw_psum+3:0]           sum_in;
  logic [bw_psum+3:0]           tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic                         tx_last;
  logic [$clog2(depth):0]       level;
  logic                         overflow;
  logic                         clr_ovf;

  modport master (
    output cap_valid, out_in, sum_in, tx_ready, clr_ovf,
    input  tx_data, tx_valid, tx_last, level, overflow
  );

  modport slave (
    input  cap_valid, out_in, sum_in, tx_ready, clr_ovf,
    output tx_data, tx_valid, tx_last, level, overflow
  );
endinterface

// File: rtl/psum_collector.sv
// Row FIFO for captured psum rows, serialised one sign-extended word per beat.
// `define PSUM_COLLECTOR_SUM_BEAT_EN adds the stored sum word as a final beat of each row.
module psum_collector #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int depth   = 4
) (
  input  logic             clk,
  input  logic             reset,
  psum_collector_if.slave  bus
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int LW = AW + 1;
  localparam int SW = bw_psum + 4;
  localparam int RW = bw_psum * col;
`ifdef PSUM_COLLECTOR_SUM_BEAT_EN
  localparam int B = col + 1;
`else
  localparam int B = col;
`endif
  localparam int BTW = (B > 1) ? $clog2(B) : 1;
  localparam logic [LW-1:0]  DEPTH_L   = LW'(depth);
  localparam logic [BTW-1:0] LAST_BEAT = BTW'(B - 1);

  function automatic logic signed [SW-1:0] sext(input logic signed [bw_psum-1:0] v);
    return {{4{v[bw_psum-1]}}, v};
  endfunction

  logic [RW-1:0]         row_mem [depth];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [BTW-1:0]        beat_q, beat_d;
  logic                  ovf_q, ovf_d;
  logic                  vld, last_beat, fire, pop, push, drop;
  logic signed [SW-1:0]  head_word;

  assign vld       = (cnt_q != '0);
  assign last_beat = (beat_q == LAST_BEAT);
  assign fire      = vld & bus.tx_ready;
  assign pop       = fire & last_beat;
  // A full FIFO still accepts a row when the head row leaves on the same edge.
  assign push      = bus.cap_valid & ((cnt_q < DEPTH_L) | pop);
  assign drop      = bus.cap_valid & ~push;

  always_ff @(posedge clk) begin
    if (push) row_mem[wr_ptr_q] <= bus.out_in;
  end

`ifdef PSUM_COLLECTOR_SUM_BEAT_EN
  logic [SW-1:0] sum_mem [depth];

  always_ff @(posedge clk) begin
    if (push) sum_mem[wr_ptr_q] <= bus.sum_in;
  end
`else
  logic unused_sum;
  assign unused_sum = ^bus.sum_in;
`endif

  always_comb begin
    head_word = '0;
    for (int k = 0; k < col; k++) begin
      if (beat_q == BTW'(k)) head_word = sext(row_mem[rd_ptr_q][k*bw_psum +: bw_psum]);
    end
`ifdef PSUM_COLLECTOR_SUM_BEAT_EN
    if (last_beat) head_word = sum_mem[rd_ptr_q];
`endif
  end

  assign bus.tx_data  = vld ? head_word : '0;
  assign bus.tx_valid = vld;
  assign bus.tx_last  = vld & last_beat;
  assign bus.level    = cnt_q;
  assign bus.overflow = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q;
    if (fire) beat_d = last_beat ? '0 : beat_q + BTW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    if (bus.clr_ovf) ovf_d = 1'b0;
    if (drop)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: expected beats are queued at capture time and popped on each handshake.
`timescale 1ns/1ps
module tb_psum_collector;
  localparam int COL   = 8;
  localparam int BW    = 20;
  localparam int DEPTH = 4;
  localparam int SW    = BW + 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PSUM_COLLECTOR_SUM_BEAT_EN
  localparam int B = COL + 1;
`else
  localparam int B = COL;
`endif

  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_collector_if #(.col(COL), .bw_psum(BW), .depth(DEPTH)) bus ();

  psum_collector #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic int pval(int r, int k);
    if (r == 0) return (k % 2 == 0) ? (k / 2 + 1) : -(k / 2 + 1);
    if (k == 6) return 524287;
    if (k == 7) return -524288;
    return ((r * 7919 + k * 104729) % 1048576) - 524288;
  endfunction

  function automatic logic [SW-1:0] sval(int r);
    if (r == 0) return 24'h00ABCD;
    return SW'(r * 4919) ^ 24'h800000;
  endfunction

  task automatic set_cap(input int r);
    logic [BW*COL-1:0] row;
    for (int k = 0; k < COL; k++) row[k*BW +: BW] = BW'(pval(r, k));
    bus.cap_valid = 1'b1;
    bus.out_in    = row;
    bus.sum_in    = sval(r);
  endtask

  task automatic push_exp(input int r);
    beat_t b;
    for (int k = 0; k < COL; k++) begin
      b.data = SW'(pval(r, k));
      b.last = (k == B - 1);
      sb.push_back(b);
    end
`ifdef PSUM_COLLECTOR_SUM_BEAT_EN
    b.data = sval(r);
    b.last = 1'b1;
    sb.push_back(b);
`endif
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.cap_valid = 1'b0;
    bus.out_in    = '0;
    bus.sum_in    = '0;
    bus.tx_ready  = 1'b0;
    bus.clr_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_last !== 1'b0) begin n_err++; $display("FAIL reset_tx_last: got %b want 0", bus.tx_last); end
    n_cmp++; if (bus.tx_data !== '0) begin n_err++; $display("FAIL reset_tx_data: got %h want 0", bus.tx_data); end
    n_cmp++; if (bus.level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.tx_valid !== 1'b0 || bus.level !== '0) begin n_err++; $display("FAIL release_idle: got valid=%b level=%0d want 0/0", bus.tx_valid, bus.level); end
  endtask

  task automatic test_single_row();
    beat_t e;
    int    c;
    set_cap(0);
    push_exp(0);
    bus.tx_ready = 1'b1;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL single_pre_valid: got %b want 0", bus.tx_valid); end
    @(negedge clk);
    bus.cap_valid = 1'b0;
    n_cmp++; if (bus.tx_valid !== 1'b1 || bus.level !== LW'(1)) begin n_err++; $display("FAIL single_first_valid: got valid=%b level=%0d want 1/1", bus.tx_valid, bus.level); end
    for (c = 0; c < 100 && sb.size() != 0; c++) begin
      if (bus.tx_valid && bus.tx_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.tx_data !== e.data || bus.tx_last !== e.last) begin
          n_err++; $display("FAIL single_beat: got data=%h last=%b want data=%h last=%b", bus.tx_data, bus.tx_last, e.data, e.last);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin n_cmp++; n_err++; $display("FAIL single_timeout: got %0d beats left want 0", sb.size()); sb.delete(); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL single_extra_beat: got valid=%b want 0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    beat_t         e;
    int            c;
    logic          hold_v;
    logic [SW-1:0] hold_d;
    set_cap(2);
    push_exp(2);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    bus.cap_valid = 1'b0;
    hold_v = 1'b0;
    hold_d = '0;
    for (c = 0; c < 200 && sb.size() != 0; c++) begin
      bus.tx_ready = (c % 4 == 0) || (c % 4 == 3);
      if (hold_v) begin
        n_cmp++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== hold_d) begin
          n_err++; $display("FAIL bp_hold: got valid=%b data=%h want 1/%h", bus.tx_valid, bus.tx_data, hold_d);
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.tx_data !== e.data || bus.tx_last !== e.last) begin
          n_err++; $display("FAIL bp_beat: got data=%h last=%b want data=%h last=%b", bus.tx_data, bus.tx_last, e.data, e.last);
        end
      end
      hold_v = bus.tx_valid && !bus.tx_ready;
      hold_d = bus.tx_data;
      @(negedge clk);
    end
    if (sb.size() != 0) begin n_cmp++; n_err++; $display("FAIL bp_timeout: got %0d beats left want 0", sb.size()); sb.delete(); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra_beat: got valid=%b want 0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_fill();
    beat_t e;
    int    c;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_cap(10 + i);
      bus.clr_ovf = (i == 5);
      if (i < 4) push_exp(10 + i);
      if (i == 4) begin
        n_cmp++; if (bus.level !== LW'(4) || bus.overflow !== 1'b0) begin n_err++; $display("FAIL fill_full: got level=%0d ovf=%b want 4/0", bus.level, bus.overflow); end
      end
      if (i == 5) begin
        n_cmp++; if (bus.level !== LW'(4) || bus.overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow: got level=%0d ovf=%b want 4/1", bus.level, bus.overflow); end
      end
      @(negedge clk);
    end
    bus.cap_valid = 1'b0;
    bus.clr_ovf   = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b1 || bus.level !== LW'(4)) begin n_err++; $display("FAIL fill_set_wins: got ovf=%b level=%0d want 1/4", bus.overflow, bus.level); end
    bus.tx_ready = 1'b1;
    for (c = 0; c < 200 && sb.size() != 0; c++) begin
      if (bus.tx_valid && bus.tx_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.tx_data !== e.data || bus.tx_last !== e.last) begin
          n_err++; $display("FAIL fill_beat: got data=%h last=%b want data=%h last=%b", bus.tx_data, bus.tx_last, e.data, e.last);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin n_cmp++; n_err++; $display("FAIL fill_timeout: got %0d beats left want 0", sb.size()); sb.delete(); end
    n_cmp++; if (bus.tx_valid !== 1'b0 || bus.level !== '0) begin n_err++; $display("FAIL fill_drained: got valid=%b level=%0d want 0/0", bus.tx_valid, bus.level); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fill_sticky: got ovf=%b want 1", bus.overflow); end
    bus.tx_ready = 1'b0;
    bus.clr_ovf  = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fill_clear: got ovf=%b want 0", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int    c;
    int    extra;
    logic  chk;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cap(20 + i);
      push_exp(20 + i);
      @(negedge clk);
    end
    bus.cap_valid = 1'b0;
    n_cmp++; if (bus.level !== LW'(4)) begin n_err++; $display("FAIL b2b_prefill: got level=%0d want 4", bus.level); end
    bus.tx_ready = 1'b1;
    extra = 0;
    chk   = 1'b0;
    for (c = 0; c < 400 && sb.size() != 0; c++) begin
      bus.cap_valid = 1'b0;
      if (chk) begin
        n_cmp++;
        if (bus.level !== LW'(4) || bus.overflow !== 1'b0) begin
          n_err++; $display("FAIL b2b_full_pop: got level=%0d ovf=%b want 4/0", bus.level, bus.overflow);
        end
        chk = 1'b0;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.tx_data !== e.data || bus.tx_last !== e.last) begin
          n_err++; $display("FAIL b2b_beat: got data=%h last=%b want data=%h last=%b", bus.tx_data, bus.tx_last, e.data, e.last);
        end
        if (e.last && extra < 4) begin
          set_cap(24 + extra);
          push_exp(24 + extra);
          extra++;
          chk = 1'b1;
        end
      end
      @(negedge clk);
    end
    bus.cap_valid = 1'b0;
    if (sb.size() != 0) begin n_cmp++; n_err++; $display("FAIL b2b_timeout: got %0d beats left want 0", sb.size()); sb.delete(); end
    n_cmp++; if (c != 8 * B) begin n_err++; $display("FAIL b2b_no_gap: got %0d cycles want %0d", c, 8 * B); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_extra_beat: got valid=%b want 0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_row();
    beat_t e;
    int    c;
    set_cap(30);
    push_exp(30);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.cap_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== e.data) begin
        n_err++; $display("FAIL mid_pre_beat: got valid=%b data=%h want 1/%h", bus.tx_valid, bus.tx_data, e.data);
      end
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.tx_valid !== 1'b0 || bus.tx_last !== 1'b0) begin n_err++; $display("FAIL mid_reset_ctl: got valid=%b last=%b want 0/0", bus.tx_valid, bus.tx_last); end
    n_cmp++; if (bus.tx_data !== '0) begin n_err++; $display("FAIL mid_reset_data: got %h want 0", bus.tx_data); end
    n_cmp++; if (bus.level !== '0 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL mid_reset_level: got level=%0d ovf=%b want 0/0", bus.level, bus.overflow); end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_release_idle: got valid=%b want 0", bus.tx_valid); end
    set_cap(31);
    push_exp(31);
    @(negedge clk);
    bus.cap_valid = 1'b0;
    for (c = 0; c < 100 && sb.size() != 0; c++) begin
      if (bus.tx_valid && bus.tx_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.tx_data !== e.data || bus.tx_last !== e.last) begin
          n_err++; $display("FAIL mid_restart_beat: got data=%h last=%b want data=%h last=%b", bus.tx_data, bus.tx_last, e.data, e.last);
        end
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin n_cmp++; n_err++; $display("FAIL mid_timeout: got %0d beats left want 0", sb.size()); sb.delete(); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_extra_beat: got valid=%b want 0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_fill();
    test_back_to_back();
    test_reset_mid_row();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
